// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift transfer controller.
// Holds the sequencer state encoding and bit-count normalisation.
package shift_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // A zero or oversized request means "shift the whole word".
  function automatic int unsigned norm_len(
    input int unsigned len,
    input int unsigned bits
  );
    return (len == 32'd0 || len > bits) ? bits : len;
  endfunction

endpackage

// File: rtl/shift_xfer_ctrl.sv
// Sequencer for a parallel/serial shift register: load, shift N
// bits, capture the received word and hand it back.
module shift_xfer_ctrl
  import shift_pkg::*;
#(
  parameter  int BIT = 8,
  localparam int CW  = $clog2(BIT + 1)
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_req_valid,
  output logic           o_req_ready,
  input  logic [BIT-1:0] i_req_data,
  input  logic [CW-1:0]  i_req_len,
  output logic           o_rsp_valid,
  input  logic           i_rsp_ready,
  output logic [BIT-1:0] o_rsp_data,
  input  logic           i_abort,
  output logic           o_busy,
  output logic           o_sr_load,
  output logic           o_sr_shift_en,
  output logic [BIT-1:0] o_sr_data,
  input  logic [BIT-1:0] i_sr_parallel
);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BIT-1:0] sr_data_q, sr_data_d;
  logic [BIT-1:0] rsp_q, rsp_d;
  logic           accept;
  logic           abort_ok;

  assign accept   = (state_q == IDLE) && i_req_valid;
  assign abort_ok = i_abort &&
                    (state_q inside {LOAD, SHIFT, CAPT});

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (i_req_valid) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: if (cnt_q == CW'(1)) state_d = CAPT;
      CAPT:  state_d = RESP;
      RESP:  if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_ok) state_d = IDLE;
  end

  always_comb begin
    cnt_d     = cnt_q;
    sr_data_d = sr_data_q;
    rsp_d     = rsp_q;
    if (accept) begin
      sr_data_d = i_req_data;
      cnt_d     = CW'(norm_len(32'(i_req_len), BIT));
    end
    if (state_q == SHIFT) cnt_d = cnt_q - CW'(1);
    // An abort in CAPT must leave the last good response intact.
    if (state_q == CAPT && !i_abort) rsp_d = i_sr_parallel;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q     <= '0;
      sr_data_q <= '0;
      rsp_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      sr_data_q <= sr_data_d;
      rsp_q     <= rsp_d;
    end
  end

  always_comb begin
    o_req_ready   = 1'b0;
    o_sr_load     = 1'b0;
    o_sr_shift_en = 1'b0;
    o_rsp_valid   = 1'b0;
    o_busy        = 1'b1;
    unique case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
      end
      LOAD:  o_sr_load     = 1'b1;
      SHIFT: o_sr_shift_en = 1'b1;
      CAPT:  ;
      RESP:  o_rsp_valid   = 1'b1;
      default: ;
    endcase
  end

  assign o_sr_data  = sr_data_q;
  assign o_rsp_data = rsp_q;

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Randomised bench for shift_xfer_ctrl with a loopback shift
// register and a rotate-based reference model.
module tb_shift_xfer_ctrl;

  localparam int BIT = 8;
  localparam int CW  = $clog2(BIT + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_req_valid, i_rsp_ready, i_abort;
  logic [BIT-1:0] i_req_data;
  logic [CW-1:0]  i_req_len;
  logic           o_req_ready, o_rsp_valid, o_busy;
  logic           o_sr_load, o_sr_shift_en;
  logic [BIT-1:0] o_rsp_data, o_sr_data;
  logic [BIT-1:0] sr = '0;
  logic [BIT-1:0] last_rsp = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_xfer_ctrl #(.BIT(BIT)) dut (
    .i_clk(clk),
    .i_rstn(rst_n),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_data(i_req_data),
    .i_req_len(i_req_len),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data),
    .i_abort(i_abort),
    .o_busy(o_busy),
    .o_sr_load(o_sr_load),
    .o_sr_shift_en(o_sr_shift_en),
    .o_sr_data(o_sr_data),
    .i_sr_parallel(sr)
  );

  // Loopback datapath: serial out feeds serial in (rotate right).
  always @(posedge clk) begin
    if (o_sr_load) sr <= o_sr_data;
    else if (o_sr_shift_en) sr <= {sr[0], sr[BIT-1:1]};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nlen(input int l);
    return (l == 0 || l > BIT) ? BIT : l;
  endfunction

  function automatic logic [BIT-1:0] rotr(input logic [BIT-1:0] d,
                                          input int n);
    logic [2*BIT-1:0] w;
    w = {d, d} >> n;
    return w[BIT-1:0];
  endfunction

  task automatic xfer(input logic [BIT-1:0] d, input logic [CW-1:0] len,
                      input int delay, input int abort_at);
    int n, cyc, loads, shifts, first_sh, last_sh;
    int rsp_cyc, idle_cyc, ld_cyc, es;
    logic [BIT-1:0] ld_val, exp_d;
    bit ab;
    n = nlen(int'(len));
    exp_d = rotr(d, n);
    ab = (abort_at >= 1 && abort_at <= n + 2);
    loads = 0; shifts = 0; first_sh = 0; last_sh = 0;
    rsp_cyc = 0; idle_cyc = 0; ld_cyc = 0; ld_val = '0;
    @(negedge clk);
    chk("req_ready_pre", 32'(o_req_ready), 1);
    i_req_valid = 1'b1;
    i_req_data = d;
    i_req_len = len;
    cyc = 1;
    @(negedge clk);
    while (cyc <= 40 && rsp_cyc == 0 && idle_cyc == 0) begin
      if (o_sr_load) begin
        loads++;
        ld_cyc = cyc;
        ld_val = o_sr_data;
      end
      if (o_sr_shift_en) begin
        shifts++;
        if (first_sh == 0) first_sh = cyc;
        last_sh = cyc;
      end
      if (o_sr_load && o_sr_shift_en) chk("ld_sh_excl", 1, 0);
      if (o_rsp_valid) rsp_cyc = cyc;
      else if (!o_busy) idle_cyc = cyc;
      else begin
        i_abort = (cyc == abort_at);
        i_req_valid = 1'($urandom);
        i_req_data = BIT'($urandom);
        i_rsp_ready = 1'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    i_abort = 1'b0;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    if (rsp_cyc == 0 && idle_cyc == 0) chk("timeout", 0, 1);
    chk("load_cnt", loads, 1);
    chk("load_cyc", ld_cyc, 1);
    chk("load_val", 32'(ld_val), 32'(d));
    if (ab) begin
      es = ((abort_at < n + 1) ? abort_at : n + 1) - 1;
      chk("abort_shifts", shifts, es);
      chk("abort_norsp", rsp_cyc, 0);
      chk("abort_idle_cyc", idle_cyc, abort_at + 1);
      chk("abort_rsp_hold", 32'(o_rsp_data), 32'(last_rsp));
      chk("abort_ready", 32'(o_req_ready), 1);
    end else begin
      chk("shift_cnt", shifts, n);
      chk("shift_first", first_sh, 2);
      chk("shift_last", last_sh, n + 1);
      chk("rsp_cyc", rsp_cyc, n + 3);
      chk("rsp_data", 32'(o_rsp_data), 32'(exp_d));
      chk("rsp_ready_low", 32'(o_req_ready), 0);
      for (int k = 0; k < delay; k++) begin
        i_abort = (cyc == abort_at);
        @(negedge clk);
        cyc++;
        i_abort = 1'b0;
        chk("bp_valid", 32'(o_rsp_valid), 1);
        chk("bp_data", 32'(o_rsp_data), 32'(exp_d));
        chk("bp_ready", 32'(o_req_ready), 0);
      end
      i_rsp_ready = 1'b1;
      i_abort = (cyc == abort_at);
      @(negedge clk);
      i_rsp_ready = 1'b0;
      i_abort = 1'b0;
      chk("post_valid", 32'(o_rsp_valid), 0);
      chk("post_ready", 32'(o_req_ready), 1);
      chk("post_data", 32'(o_rsp_data), 32'(exp_d));
      last_rsp = exp_d;
    end
    chk("sr_data_hold", 32'(o_sr_data), 32'(d));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(o_req_ready), 1);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_load"}, 32'(o_sr_load), 0);
    chk({tag, "_shift"}, 32'(o_sr_shift_en), 0);
    chk({tag, "_valid"}, 32'(o_rsp_valid), 0);
    chk({tag, "_rdata"}, 32'(o_rsp_data), 0);
    chk({tag, "_sdata"}, 32'(o_sr_data), 0);
  endtask

  initial begin
    int n, ab, acc_n, seen;
    int acc[2];
    logic [BIT-1:0] rsps[$];
    bit pend;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    i_abort = 1'b0;
    i_req_data = '0;
    i_req_len = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst");

    xfer(8'hA5, 4'd8, 0, 0);
    xfer(8'h5A, 4'd3, 0, 0);
    xfer(8'hC7, 4'd0, 1, 0);
    xfer(8'h1E, 4'd12, 0, 0);
    xfer(8'h96, 4'd5, 5, 0);
    xfer(8'hF0, 4'd8, 0, 4);
    xfer(8'h81, 4'd6, 2, 9);
    xfer(8'h42, 4'd1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 15);
      ab = 0;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, nlen(n) + 3);
      xfer(BIT'($urandom), CW'(n), $urandom_range(0, 4), ab);
    end

    // Reset in the middle of a shift drops the transfer.
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_data = 8'h77;
    i_req_len = 4'd8;
    @(negedge clk);
    i_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_shift", 32'(o_sr_shift_en), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (o_rsp_valid || o_busy) seen++;
    end
    chk("arst_quiet", seen, 0);
    last_rsp = '0;

    // Back-to-back requests with valid held high.
    acc_n = 0;
    pend = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_data = 8'h3C;
    i_req_len = 4'd8;
    i_rsp_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (pend) begin
        pend = 1'b0;
        if (acc_n == 1) i_req_data = 8'hC3;
        else i_req_valid = 1'b0;
      end
      if (o_req_ready && i_req_valid && acc_n < 2) begin
        acc[acc_n] = t;
        acc_n++;
        pend = 1'b1;
      end
      if (o_rsp_valid) rsps.push_back(o_rsp_data);
      if (rsps.size() == 2) break;
      @(negedge clk);
    end
    @(negedge clk);
    i_rsp_ready = 1'b0;
    i_req_valid = 1'b0;
    chk("b2b_accepts", acc_n, 2);
    chk("b2b_gap", acc[1] - acc[0], 12);
    chk("b2b_nrsp", rsps.size(), 2);
    if (rsps.size() == 2) begin
      chk("b2b_rsp0", 32'(rsps[0]), 32'h3C);
      chk("b2b_rsp1", 32'(rsps[1]), 32'hC3);
    end
    @(negedge clk);
    chk("b2b_idle", 32'(o_req_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
